// File: rtl/sram_fifo_client_if.sv
// Byte-stream and SRAM-controller request/hint signals of one FIFO client port.
// master: the client itself; slave: the SPI engine / controller side.
interface sram_fifo_client_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_hint;
  logic        fifo_full;
  logic        fifo_empty;
  logic        busy;
  logic        timeout_err;
  logic        clr_err;

  modport master (
    input  in_valid, in_data, flush, out_ready, mem_rdata, mem_hint,
           fifo_full, fifo_empty, clr_err,
    output in_ready, out_valid, out_data, mem_write, mem_read, mem_wdata,
           busy, timeout_err
  );

  modport slave (
    output in_valid, in_data, flush, out_ready, mem_rdata, mem_hint,
           fifo_full, fifo_empty, clr_err,
    input  in_ready, out_valid, out_data, mem_write, mem_read, mem_wdata,
           busy, timeout_err
  );
endinterface

// File: rtl/sram_fifo_client.sv
// SRAM FIFO client: packs bytes into 16-bit write requests and unpacks read
// words into bytes, keeping one request/hint transaction outstanding.
module sram_fifo_client #(
  parameter int unsigned TIMEOUT   = 32,
  parameter bit          LOW_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  sram_fifo_client_if.master bus
);
  localparam int unsigned   TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, GAP} state_t;

  state_t        state;
  logic [1:0]    pack_cnt;
  logic [1:0]    ucnt;
  logic [15:0]   pack_word;
  logic [15:0]   unpack_word;
  logic [15:0]   wdata_q;
  logic [TW-1:0] timer;
  logic          write_q, read_q, busy_q, err_q;
  logic          in_ready, accept, pop;
  logic [7:0]    first_b, second_b;

  assign in_ready = (pack_cnt < 2'd2);
  assign accept   = bus.in_valid && in_ready;
  assign pop      = (ucnt != 2'd0) && bus.out_ready;
  assign first_b  = LOW_FIRST ? unpack_word[7:0]  : unpack_word[15:8];
  assign second_b = LOW_FIRST ? unpack_word[15:8] : unpack_word[7:0];

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = (ucnt != 2'd0);
  assign bus.out_data    = (ucnt == 2'd1) ? second_b : first_b;
  assign bus.mem_write   = write_q;
  assign bus.mem_read    = read_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pack_cnt    <= '0;
      ucnt        <= '0;
      pack_word   <= '0;
      unpack_word <= '0;
      wdata_q     <= '0;
      timer       <= '0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // The first byte of a pair zeroes the other half, so a flushed word is ready as-is.
      if (accept) begin
        if (pack_cnt == 2'd0)
          pack_word <= LOW_FIRST ? {8'h00, bus.in_data} : {bus.in_data, 8'h00};
        else
          pack_word <= LOW_FIRST ? {bus.in_data, pack_word[7:0]}
                                 : {pack_word[15:8], bus.in_data};
        pack_cnt <= pack_cnt + 2'd1;
      end
      if (pop)
        ucnt <= ucnt - 2'd1;
      if (bus.clr_err)
        err_q <= 1'b0;

      case (state)
        IDLE: begin
          timer <= '0;
          if (pack_cnt == 2'd2 && !bus.fifo_full) begin
            state   <= WR_REQ;
            write_q <= 1'b1;
            wdata_q <= pack_word;
            busy_q  <= 1'b1;
          end else if (bus.flush && pack_cnt == 2'd1 && !accept && !bus.fifo_full) begin
            // A flushed half-word is treated as a full pack: input stalls until the hint,
            // and a timed-out flush retries the same word.
            state    <= WR_REQ;
            write_q  <= 1'b1;
            wdata_q  <= pack_word;
            busy_q   <= 1'b1;
            pack_cnt <= 2'd2;
          end else if (ucnt == 2'd0 && !bus.fifo_empty) begin
            state  <= RD_REQ;
            read_q <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        WR_REQ, RD_REQ: begin
          if (bus.mem_hint) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            state   <= GAP;
            if (state == WR_REQ) begin
              pack_cnt <= '0;
            end else begin
              unpack_word <= bus.mem_rdata;
              ucnt        <= 2'd2;
            end
          end else if (timer == TLAST) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            err_q   <= 1'b1;
            state   <= GAP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_fifo_client.sv
// Bench for sram_fifo_client: directed protocol steps, then a randomized byte/word
// traffic phase scored against queue-based stream models.
module tb_sram_fifo_client;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_fifo_client_if b();
  sram_fifo_client_if b2();

  sram_fifo_client #(.TIMEOUT(32), .LOW_FIRST(1'b1)) dut  (.clk(clk), .rst(rst), .bus(b));
  sram_fifo_client #(.TIMEOUT(4),  .LOW_FIRST(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned n, hi;

  logic [7:0]  exp_bytes[$];
  logic [7:0]  exp_out[$];
  bit          last_acc;
  bit          prev_write;
  logic [15:0] prev_wdata;
  int unsigned dly;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int unsigned k = 0;
    b.in_valid = 1'b1;
    b.in_data  = d;
    while (!b.in_ready && k < 100) begin step(); k++; end
    chk("send_ready", b.in_ready, 1);
    step();
    b.in_valid = 1'b0;
  endtask

  task automatic hint_b(input logic [15:0] rd);
    b.mem_rdata = rd;
    b.mem_hint  = 1'b1;
    step();
    b.mem_hint  = 1'b0;
  endtask

  // One cycle of random traffic with the bench acting as producer, consumer and controller.
  task automatic rcycle(input bit active);
    logic [15:0] w;
    logic [15:0] rd;
    if (last_acc || !b.in_valid) begin
      b.in_valid = active && ($urandom % 3 != 0);
      b.in_data  = 8'($urandom);
    end
    b.out_ready  = active ? ($urandom % 4 != 0) : 1'b1;
    b.fifo_full  = active ? ($urandom % 4 == 0) : 1'b0;
    b.fifo_empty = active ? ($urandom % 3 == 0) : 1'b1;
    last_acc = b.in_valid && b.in_ready;
    if (last_acc) exp_bytes.push_back(b.in_data);
    if (b.out_valid && b.out_ready) begin
      chk("rnd_out_avail", exp_out.size() != 0, 1);
      if (exp_out.size() != 0) chk("rnd_out_data", b.out_data, exp_out.pop_front());
    end
    chk("rnd_one_req", b.mem_write && b.mem_read, 0);
    if (b.mem_write && prev_write) chk("rnd_wdata_stable", b.mem_wdata, prev_wdata);
    prev_write = b.mem_write;
    prev_wdata = b.mem_wdata;
    b.mem_hint = 1'b0;
    if (b.mem_write || b.mem_read) begin
      if (dly == 0) begin
        b.mem_hint = 1'b1;
        dly = $urandom % 6;
        if (b.mem_write) begin
          chk("rnd_wr_avail", exp_bytes.size() >= 2, 1);
          if (exp_bytes.size() >= 2) begin
            w = {exp_bytes[1], exp_bytes[0]};
            void'(exp_bytes.pop_front());
            void'(exp_bytes.pop_front());
            chk("rnd_wdata", b.mem_wdata, w);
          end
        end else begin
          rd = 16'($urandom);
          b.mem_rdata = rd;
          exp_out.push_back(rd[7:0]);
          exp_out.push_back(rd[15:8]);
        end
      end else begin
        dly--;
      end
    end else if ($urandom % 8 == 0) begin
      b.mem_hint  = 1'b1;
      b.mem_rdata = 16'($urandom);
    end
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    b.in_valid = 0;  b.in_data = '0;  b.flush = 0;  b.out_ready = 0;  b.mem_rdata = '0;
    b.mem_hint = 0;  b.fifo_full = 0; b.fifo_empty = 1; b.clr_err = 0;
    b2.in_valid = 0; b2.in_data = '0; b2.flush = 0; b2.out_ready = 0; b2.mem_rdata = '0;
    b2.mem_hint = 0; b2.fifo_full = 0; b2.fifo_empty = 1; b2.clr_err = 0;
    #2 rst = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_out_data", b.out_data, 0);
    chk("rst_mem_write", b.mem_write, 0);
    chk("rst_mem_read", b.mem_read, 0);
    chk("rst_mem_wdata", b.mem_wdata, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_timeout_err", b.timeout_err, 0);
    rst = 1'b0;
    step();

    // Pack 0x11,0x22; hint after 5 request cycles
    send_byte(8'h11);
    send_byte(8'h22);
    chk("t1_in_ready_full", b.in_ready, 0);
    chk("t1_no_write_yet", b.mem_write, 0);
    step();
    chk("t1_write", b.mem_write, 1);
    chk("t1_wdata", b.mem_wdata, 16'h2211);
    chk("t1_busy", b.busy, 1);
    hi = 1;
    repeat (4) begin step(); hi += b.mem_write; end
    hint_b(16'h0);
    chk("t1_write_cycles", hi, 5);
    chk("t1_write_low", b.mem_write, 0);
    chk("t1_gap_busy", b.busy, 1);
    chk("t1_in_ready_back", b.in_ready, 1);
    step();
    chk("t1_idle", b.busy, 0);

    // Read BEEF, unpack, re-request after GAP
    b.fifo_empty = 0;
    step();
    chk("t2_read", b.mem_read, 1);
    chk("t2_no_write", b.mem_write, 0);
    b.fifo_empty = 1;
    step();
    b.out_ready = 1;
    b.fifo_empty = 0;
    hint_b(16'hBEEF);
    chk("t2_valid0", b.out_valid, 1);
    chk("t2_byte0", b.out_data, 8'hEF);
    chk("t2_read_low", b.mem_read, 0);
    step();
    chk("t2_valid1", b.out_valid, 1);
    chk("t2_byte1", b.out_data, 8'hBE);
    step();
    chk("t2_drained", b.out_valid, 0);
    chk("t2_read_low2", b.mem_read, 0);
    step();
    chk("t2_reread", b.mem_read, 1);
    b.fifo_empty = 1;
    hint_b(16'hC3A5);
    chk("t2b_byte0", b.out_data, 8'hA5);
    step();
    chk("t2b_byte1", b.out_data, 8'hC3);
    step();
    chk("t2b_drained", b.out_valid, 0);

    // Flush a single byte
    send_byte(8'h5A);
    b.flush = 1;
    step();
    b.flush = 0;
    chk("t3_write", b.mem_write, 1);
    chk("t3_wdata", b.mem_wdata, 16'h005A);
    step();
    hint_b(16'h0);
    chk("t3_write_low", b.mem_write, 0);
    chk("t3_in_ready", b.in_ready, 1);
    step();
    send_byte(8'h33);
    send_byte(8'h44);
    step();
    chk("t3_next_wdata", b.mem_wdata, 16'h4433);
    hint_b(16'h0);
    step();

    // Write and read eligible together: write first
    b.fifo_full = 1;
    send_byte(8'h01);
    send_byte(8'h02);
    step();
    chk("t4_blocked", b.mem_write, 0);
    b.fifo_full = 0;
    b.fifo_empty = 0;
    step();
    chk("t4_write_first", b.mem_write, 1);
    chk("t4_read_held", b.mem_read, 0);
    chk("t4_wdata", b.mem_wdata, 16'h0201);
    step();
    hint_b(16'h0);
    chk("t4_gap_write", b.mem_write, 0);
    chk("t4_gap_read", b.mem_read, 0);
    step();
    chk("t4_idle_read", b.mem_read, 0);
    step();
    chk("t4_read", b.mem_read, 1);
    b.fifo_empty = 1;
    hint_b(16'h7788);
    chk("t4_byte0", b.out_data, 8'h88);
    step();
    step();
    chk("t4_drained", b.out_valid, 0);

    // Timeout, sticky error, retry, set-over-clear
    send_byte(8'hA1);
    send_byte(8'hB2);
    step();
    n = 0;
    while (b.mem_write && n < 100) begin n++; step(); end
    chk("t5_req_cycles", n, 32);
    chk("t5_err", b.timeout_err, 1);
    chk("t5_gap", b.busy, 1);
    step();
    chk("t5_idle_low", b.mem_write, 0);
    step();
    chk("t5_retry", b.mem_write, 1);
    chk("t5_retry_wdata", b.mem_wdata, 16'hB2A1);
    chk("t5_err_sticky", b.timeout_err, 1);
    b.clr_err = 1;
    step();
    chk("t5_cleared", b.timeout_err, 0);
    n = 0;
    while (b.mem_write && n < 100) begin n++; step(); end
    chk("t5_req_cycles2", n, 31);
    chk("t5_set_wins", b.timeout_err, 1);
    b.clr_err = 0;
    step();
    step();
    chk("t5_retry2_wdata", b.mem_wdata, 16'hB2A1);
    chk("t5_retry2", b.mem_write, 1);
    b.clr_err = 1;
    step();
    b.clr_err = 0;
    chk("t5_cleared2", b.timeout_err, 0);
    hint_b(16'h0);
    chk("t5_done", b.mem_write, 0);
    chk("t5_in_ready", b.in_ready, 1);
    step();

    // High-byte-first instance with TIMEOUT=4
    b2.in_valid = 1; b2.in_data = 8'h11;
    step();
    b2.in_data = 8'h22;
    step();
    b2.in_valid = 0;
    step();
    chk("d2_write", b2.mem_write, 1);
    chk("d2_wdata", b2.mem_wdata, 16'h1122);
    n = 0;
    while (b2.mem_write && n < 100) begin n++; step(); end
    chk("d2_req_cycles", n, 4);
    chk("d2_err", b2.timeout_err, 1);
    step();
    step();
    chk("d2_retry_wdata", b2.mem_wdata, 16'h1122);
    b2.mem_hint = 1;
    step();
    b2.mem_hint = 0;
    chk("d2_write_low", b2.mem_write, 0);
    step();
    b2.fifo_empty = 0;
    b2.out_ready = 1;
    step();
    chk("d2_read", b2.mem_read, 1);
    b2.fifo_empty = 1;
    b2.mem_rdata = 16'hBEEF;
    b2.mem_hint = 1;
    step();
    b2.mem_hint = 0;
    chk("d2_byte0", b2.out_data, 8'hBE);
    step();
    chk("d2_byte1", b2.out_data, 8'hEF);
    step();
    chk("d2_drained", b2.out_valid, 0);

    // Async reset during a read, with a half-filled pack
    b.fifo_empty = 0;
    send_byte(8'h99);
    chk("t6_read", b.mem_read, 1);
    b.fifo_empty = 1;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_read", b.mem_read, 0);
    chk("t6_async_busy", b.busy, 0);
    #1 rst = 1'b0;
    hint_b(16'h1234);
    chk("t6_no_capture", b.out_valid, 0);
    chk("t6_idle", b.busy, 0);
    send_byte(8'h66);
    send_byte(8'h77);
    step();
    chk("t6_pack_discarded", b.mem_wdata, 16'h7766);
    hint_b(16'h0);
    step();

    // Randomized traffic against stream models
    last_acc = 0;
    prev_write = 0;
    prev_wdata = '0;
    dly = 2;
    b.in_valid = 0;
    repeat (3000) rcycle(1'b1);
    repeat (60) rcycle(1'b0);
    chk("rnd_residual_bytes", exp_bytes.size() < 2, 1);
    chk("rnd_out_left", exp_out.size(), 0);
    chk("rnd_end_idle", b.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
